// File: rtl/modn_ctr_seq_if.sv
// rtl/modn_ctr_seq_if.sv - command handshake between requester and mod-N sequencer
interface modn_ctr_seq_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_mod;
    logic [REP_W-1:0] cmd_reps;

    modport master (output cmd_valid, output cmd_mod, output cmd_reps, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_mod, input cmd_reps, output cmd_ready);
endinterface

// File: rtl/modn_ctr_seq.sv
// rtl/modn_ctr_seq.sv - command-driven mod-N counter sequencer with hold/abort and done pulse
module modn_ctr_seq #(
    parameter int WIDTH = 4,
    parameter int N     = 10,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    modn_ctr_seq_if.slave    cmd,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] eff_mod;
    logic             cmd_bad;
    logic             last_cnt;
    logic             last_rep;

    assign eff_mod  = (cmd.cmd_mod == '0) ? WIDTH'(N) : cmd.cmd_mod;
    assign cmd_bad  = (eff_mod == WIDTH'(1)) || (cmd.cmd_reps == '0);
    assign last_cnt = (out_q == mod_q - WIDTH'(1));
    assign last_rep = (rep_cnt_q == reps_q - REP_W'(1));

    always_comb begin
        state_d   = state_q;
        mod_d     = mod_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        out_d     = out_q;
        wrap_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_d = '0;
                if (cmd.cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        mod_d     = eff_mod;
                        reps_d    = cmd.cmd_reps;
                        rep_cnt_d = '0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // abort outranks both hold and the final wrap into DONE
                if (abort) begin
                    out_d   = '0;
                    state_d = S_IDLE;
                end else if (!hold) begin
                    if (last_cnt) begin
                        out_d  = '0;
                        wrap_d = 1'b1;
                        if (last_rep) begin
                            rep_cnt_d = '0;
                            done_d    = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
                    end else begin
                        out_d = out_q + WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                out_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                out_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            mod_q     <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
            out_q     <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mod_q     <= mod_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
            out_q     <= out_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign out           = out_q;
    assign wrap          = wrap_q;
    assign done          = done_q;
    assign err           = err_q;
    assign busy          = (state_q == S_RUN);
    assign cmd.cmd_ready = (state_q == S_IDLE);
endmodule

// File: tb/tb_modn_ctr_seq.sv
// tb/tb_modn_ctr_seq.sv - directed self-checking bench for modn_ctr_seq
module tb_modn_ctr_seq;
    logic       clk;
    logic       rstn;
    logic       hold;
    logic       abort;
    logic [3:0] out;
    logic       wrap;
    logic       busy;
    logic       done;
    logic       err;
    int         n_vec;
    int         n_bad;

    modn_ctr_seq_if #(.WIDTH(4), .REP_W(8)) cif ();

    modn_ctr_seq #(.WIDTH(4), .N(10), .REP_W(8)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .cmd   (cif),
        .hold  (hold),
        .abort (abort),
        .out   (out),
        .wrap  (wrap),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // returns at the negedge of the first cycle after the accept edge
    task automatic issue(input logic [3:0] m, input logic [7:0] r);
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_mod   = m;
        cif.cmd_reps  = r;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] m_cmd, input logic [7:0] r, input int hold_at,
                           input int hold_n, input int exp_done_c, input int exp_wraps);
        int   m, e_out, per, hold_rem, wraps, done_c;
        logic e_wrap, e_done;
        m = (m_cmd == 4'd0) ? 10 : int'(m_cmd);
        issue(m_cmd, r);
        e_out = 0; per = 0; hold_rem = hold_n; wraps = 0; done_c = -1;
        e_wrap = 1'b0; e_done = 1'b0;
        for (int c = 1; c <= 4000; c++) begin
            if (c > 1) @(negedge clk);
            if (wrap) wraps++;
            if (done && done_c < 0) done_c = c;
            if (e_done) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_out", out, 0);
                chk("done_wrap", wrap, 1);
                chk("done_ready", cif.cmd_ready, 0);
                break;
            end
            chk("run_out", out, e_out);
            chk("run_busy", busy, 1);
            chk("run_wrap", wrap, e_wrap);
            chk("run_done", done, 0);
            e_wrap = 1'b0;
            if (e_out == hold_at && hold_rem > 0) begin
                hold = 1'b1;
                hold_rem--;
            end else begin
                hold = 1'b0;
                if (e_out == m - 1) begin
                    e_out  = 0;
                    e_wrap = 1'b1;
                    per++;
                    if (per == int'(r)) e_done = 1'b1;
                end else begin
                    e_out++;
                end
            end
        end
        hold = 1'b0;
        @(negedge clk);
        chk("post_ready", cif.cmd_ready, 1);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("done_cycle", done_c, exp_done_c);
        chk("wrap_count", wraps, exp_wraps);
    endtask

    task automatic reject(input logic [3:0] m, input logic [7:0] r);
        issue(m, r);
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_ready", cif.cmd_ready, 1);
        chk("rej_out", out, 0);
        @(negedge clk);
        chk("rej_err_clr", err, 0);
        chk("rej_busy2", busy, 0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rstn = 1'b0; hold = 1'b0; abort = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_mod = '0; cif.cmd_reps = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cif.cmd_ready, 1);
        rstn = 1'b1;

        run_cmd(4'd0, 8'd2, -1, 0, 21, 2);

        reject(4'd1, 8'd3);
        reject(4'd0, 8'd0);
        reject(4'd5, 8'd0);

        run_cmd(4'd5, 8'd1, 2, 3, 9, 1);

        // abort in the second period at out = 4, which is cycle 12 after accept
        issue(4'd7, 8'd3);
        repeat (11) @(negedge clk);
        chk("abt_pre_out", out, 4);
        chk("abt_pre_busy", busy, 1);
        abort = 1'b1;
        hold  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        hold  = 1'b0;
        chk("abt_out", out, 0);
        chk("abt_busy", busy, 0);
        chk("abt_done", done, 0);
        chk("abt_wrap", wrap, 0);
        chk("abt_ready", cif.cmd_ready, 1);
        cif.cmd_valid = 1'b1; cif.cmd_mod = 4'd3; cif.cmd_reps = 8'd1;
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("abt_new_busy", busy, 1);
        chk("abt_new_out", out, 0);
        chk("abt_done_late", done, 0);
        repeat (3) @(negedge clk);
        chk("abt_new_done", done, 1);
        @(negedge clk);

        // reset mid-run at out = 8
        issue(4'd15, 8'd1);
        repeat (8) @(negedge clk);
        chk("mrst_pre_out", out, 8);
        rstn = 1'b0;
        #1;
        chk("mrst_out", out, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_ready", cif.cmd_ready, 1);
        @(negedge clk);
        rstn = 1'b1;

        // cmd_valid held high through DONE: re-accept only once back in IDLE
        @(negedge clk);
        cif.cmd_valid = 1'b1; cif.cmd_mod = 4'd15; cif.cmd_reps = 8'd1;
        @(negedge clk);
        chk("rr_busy", busy, 1);
        repeat (15) @(negedge clk);
        chk("rr_done", done, 1);
        chk("rr_done_ready", cif.cmd_ready, 0);
        @(negedge clk);
        chk("rr_idle_ready", cif.cmd_ready, 1);
        chk("rr_idle_busy", busy, 0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("rr_second_busy", busy, 1);
        chk("rr_second_out", out, 0);
        chk("rr_second_err", err, 0);
        repeat (15) @(negedge clk);
        chk("rr_second_done", done, 1);

        run_cmd(4'd2, 8'd255, -1, 0, 511, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/modn_ctr_seq.md
# modn_ctr_seq

Command-driven sequencer for a mod-N counter. A requester issues a (modulus, repeat-count) command over a valid/ready handshake. The block then runs the count sequence 0..M-1 for exactly R full periods, with optional hold and abort, and signals completion with a one-cycle done pulse. It sits in front of the mod-N counter datapath and gives software-style control over modulus and run length without rebuilding the counter.

## Interface
- WIDTH, 4: count and modulus width.
- N, 10: default modulus, used when cmd_mod = 0; must satisfy 2 <= N <= 2^WIDTH-1.
- REP_W, 8: repeat-count width.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_mod  in  WIDTH  modulus M; 0 selects N; 1 is illegal.
- cmd_reps  in  REP_W  number of full periods R; 0 is illegal.
- hold  in  1  freezes counting while high (RUN only).
- abort  in  1  terminates the run (RUN only).
- out  out  WIDTH  current count.
- wrap  out  1  one-cycle pulse on each M-1 -> 0 transition.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on a rejected command.

## Operation
- **States:** IDLE, RUN, DONE.
- **Registers:** mod_r (WIDTH), reps_r (REP_W), rep_cnt (REP_W), out (WIDTH).
- **IDLE:**
  - cmd_ready = 1, out = 0.
  - Accept = cmd_valid & cmd_ready at a clock edge.
  - If the effective M is 1 or cmd_reps = 0: err pulses the next cycle and the block stays in IDLE.
  - Otherwise: latch mod_r and reps_r, clear rep_cnt, enter RUN.
- **RUN:**
  - When hold = 0:
    - out < mod_r-1: out increments.
    - out = mod_r-1: out <- 0, wrap pulses next cycle, rep_cnt increments.
    - If out = mod_r-1 and rep_cnt = reps_r-1: next state is DONE.
  - When hold = 1: out and rep_cnt freeze, no wrap.
  - abort = 1: next state is IDLE, out <- 0, no done, no wrap. abort has priority over hold and over the final-wrap transition.
  - cmd_valid is ignored; cmd_ready = 0.
- **DONE:**
  - done = 1 and out = 0 for exactly one cycle.
  - cmd_ready = 0.
  - Unconditional return to IDLE.
- **Arithmetic:** unsigned compare against mod_r-1. out never exceeds mod_r-1. rep_cnt never exceeds reps_r-1.
- hold and abort have no effect in IDLE or DONE.

## Timing
- **Reset values (async assert, sync-free deassert):**
  - Outputs: out = 0, wrap = 0, busy = 0, done = 0, err = 0, cmd_ready = 1.
  - Internal: state IDLE, all registers 0.
- **Accept at edge k:**
  - Cycle k+1: busy = 1, out = 0.
  - With no hold, out = j mod M in cycle k+1+j.
- **Final period:**
  - Last out = M-1 occurs in cycle k+M*R.
  - Cycle k+M*R+1: DONE, done = 1, wrap = 1, busy = 0.
  - Cycle k+M*R+2: IDLE, cmd_ready = 1.
  - The earliest next accept is at the edge ending cycle k+M*R+2.
- **Latency:** accept-to-done = M*R+1 cycles plus one cycle per held cycle.
- **Rejected command at edge k:** err = 1 in cycle k+1; cmd_ready stays 1.
- **Outputs:** wrap, done and err are registered.
- **cmd_ready** is decoded from state only; it has no combinational path from cmd_valid.
- **Reset mid-run:** all outputs return to reset values immediately; no done pulse.

## Test plan
- **Default modulus:** reset 2 cycles, then cmd_mod = 0, cmd_reps = 2.
  - out = 0..9, 0..9.
  - wrap in cycles k+11 and k+21; done = 1 in cycle k+21.
  - IDLE and cmd_ready = 1 in cycle k+22.
- **Illegal commands:** cmd_mod = 1, then cmd_reps = 0.
  - err pulses once each; busy stays 0; out stays 0.
- **Hold:** M = 5, R = 1; hold high for 3 cycles while out = 2.
  - out stays 2 for 3 extra cycles.
  - done at k+9 instead of k+6.
- **Abort:** M = 7, R = 3; abort while out = 4 in period 2.
  - Next cycle: IDLE, out = 0, done never pulses.
  - A new command is accepted on the following edge.
- **Reset mid-run, then command during DONE:** M = 15, R = 1; deassert rstn at out = 8.
  - Immediately: out = 0, busy = 0.
  - Rerun with cmd_valid held high through DONE: not accepted until IDLE; the second run starts 2 cycles after done.
- **Boundary:** M = 2, R = 2^REP_W-1.
  - out alternates 0/1.
  - Exactly 255 wrap pulses; done at cycle k+511.
